piso_tx: RTL and testbench

Parallel-in/serial-out transmitter with a valid/ready load handshake. It accepts a WIDTH-bit word and shifts it out one bit per clock on `sout`, qualified by `sout_valid` and `sout_last`. It is the sending end of the single-bit serial path that our flip-flop and serial-capture blocks sample, and it feeds them in testbenches and top-levels. A free-running frame counter lets verification cross-check the number of words sent.

---
 rtl/piso_tx.sv | 109 ++++++++++
 tb/tb_piso_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit per clock, with back-to-back reload on the last bit.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] sr_shifted;
    logic [BW-1:0]    bcnt;
    logic [BW-1:0]    bcnt_nxt;
    logic             out_bit;
    logic             on_last;
    logic             accept;
    logic             frame_inc;

    // The output end of the shift register depends on bit order; vacated bits fill with zero.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
            assign out_bit    = sr[0];
        end else begin : g_msb_first
            assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
            assign out_bit    = sr[WIDTH-1];
        end
    endgenerate

    assign on_last    = (state == SHIFT) && (bcnt == LAST_BIT);
    assign load_ready = (state == IDLE) || on_last;
    assign accept     = load_valid && load_ready;

    assign sout       = (state == SHIFT) && out_bit;
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign sout_last  = on_last;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        bcnt_nxt  = bcnt;
        frame_inc = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_nxt    = load_data;
                    bcnt_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt   = sr_shifted;
                bcnt_nxt = bcnt + BW'(1);
                if (on_last) begin
                    frame_inc = 1'b1;
                    bcnt_nxt  = '0;
                    state_nxt = IDLE;
                end
                // A reload on the last bit keeps the line busy with no gap bit.
                if (accept) begin
                    sr_nxt    = load_data;
                    bcnt_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            bcnt      <= '0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            bcnt  <= bcnt_nxt;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a word-level reference model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;

    logic       msb_ready, msb_sout, msb_valid, msb_last, msb_busy;
    logic [7:0] msb_frame;
    logic       lsb_ready, lsb_sout, lsb_valid, lsb_last, lsb_busy;
    logic [7:0] lsb_frame;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current word (-1 when idle), the word, words sent.
    int         ref_pos = -1;
    logic [7:0] ref_word = 8'h00;
    int         ref_frames = 0;

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(msb_ready), .sout(msb_sout), .sout_valid(msb_valid),
        .sout_last(msb_last), .busy(msb_busy), .frame_cnt(msb_frame)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(lsb_ready), .sout(lsb_sout), .sout_valid(lsb_valid),
        .sout_last(lsb_last), .busy(lsb_busy), .frame_cnt(lsb_frame)
    );

    initial forever #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input bit lsb);
        if (ref_pos < 0) return 1'b0;
        return lsb ? ref_word[ref_pos] : ref_word[7 - ref_pos];
    endfunction

    // A word is eight bit-times long; a new one can start when idle or on the final bit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_pos    <= -1;
            ref_word   <= 8'h00;
            ref_frames <= 0;
        end else begin
            if (ref_pos == 7) ref_frames <= ref_frames + 1;
            if (load_valid && (ref_pos < 0 || ref_pos == 7)) begin
                ref_word <= load_data;
                ref_pos  <= 0;
            end else if (ref_pos == 7) begin
                ref_pos <= -1;
            end else if (ref_pos >= 0) begin
                ref_pos <= ref_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        check_output("msb_sout",  {31'd0, msb_sout},  {31'd0, exp_bit(1'b0)});
        check_output("lsb_sout",  {31'd0, lsb_sout},  {31'd0, exp_bit(1'b1)});
        check_output("valid",     {30'd0, msb_valid, lsb_valid}, {30'd0, {2{ref_pos >= 0}}});
        check_output("busy",      {30'd0, msb_busy, lsb_busy},   {30'd0, {2{ref_pos >= 0}}});
        check_output("last",      {30'd0, msb_last, lsb_last},   {30'd0, {2{ref_pos == 7}}});
        check_output("ready",     {30'd0, msb_ready, lsb_ready},
                     {30'd0, {2{ref_pos < 0 || ref_pos == 7}}});
        check_output("frame_cnt", {16'd0, msb_frame, lsb_frame},
                     {16'd0, {2{8'(ref_frames % 256)}}});
    end

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called on a falling edge with the transmitter idle; returns on the falling edge of bit 7.
    task automatic apply_stimulus(input logic [7:0] w, output logic [7:0] seq_msb,
                                  output logic [7:0] seq_lsb);
        seq_msb = 8'h00;
        seq_lsb = 8'h00;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seq_msb = {seq_msb[6:0], msb_sout};
            seq_lsb = {seq_lsb[6:0], lsb_sout};
            if (i < 7) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  sm, sl;
        logic [15:0] seq16, rdy16;
        int          waited;

        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rst_valid", {31'd0, msb_valid}, 32'd0);
            check_output("rst_ready", {31'd0, msb_ready}, 32'd1);
            check_output("rst_frame", {24'd0, msb_frame}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_output("accept_after_release", {31'd0, msb_valid}, 32'd1);
        repeat (9) @(negedge clk);

        apply_reset();
        apply_stimulus(8'hA5, sm, sl);
        check_output("a5_msb_seq", {24'd0, sm}, 32'hA5);
        check_output("a5_lsb_seq", {24'd0, sl}, 32'hA5);
        @(negedge clk);
        check_output("a5_idle", {31'd0, msb_valid}, 32'd0);
        check_output("a5_frame", {24'd0, msb_frame}, 32'd1);

        apply_stimulus(8'h01, sm, sl);
        check_output("01_msb_seq", {24'd0, sm}, 32'h01);
        check_output("01_lsb_seq", {24'd0, sl}, 32'h80);
        @(negedge clk);

        apply_reset();
        check_output("b2b_idle_ready", {31'd0, msb_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = 8'hF0;
        @(negedge clk);
        load_data = 8'h0F;
        seq16 = 16'h0;
        rdy16 = 16'h0;
        for (int i = 0; i < 16; i++) begin
            seq16 = {seq16[14:0], msb_sout};
            rdy16 = {rdy16[14:0], msb_ready};
            check_output("b2b_contig", {31'd0, msb_valid}, 32'd1);
            if (i == 8) load_valid = 1'b0;
            if (i < 15) @(negedge clk);
        end
        check_output("b2b_seq", {16'd0, seq16}, 32'hF00F);
        check_output("b2b_ready", {16'd0, rdy16}, 32'h0101);
        @(negedge clk);
        check_output("b2b_frame", {24'd0, msb_frame}, 32'd2);

        apply_reset();
        load_valid = 1'b1;
        load_data  = 8'hC3;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_sout",  {31'd0, msb_sout},  32'd0);
        check_output("mid_rst_valid", {31'd0, msb_valid}, 32'd0);
        check_output("mid_rst_last",  {31'd0, msb_last},  32'd0);
        check_output("mid_rst_busy",  {31'd0, msb_busy},  32'd0);
        check_output("mid_rst_ready", {31'd0, msb_ready}, 32'd1);
        check_output("mid_rst_frame", {24'd0, msb_frame}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(8'h81, sm, sl);
        check_output("81_msb_seq", {24'd0, sm}, 32'h81);
        check_output("81_lsb_seq", {24'd0, sl}, 32'h81);
        @(negedge clk);
        check_output("81_frame", {24'd0, msb_frame}, 32'd1);

        apply_reset();
        for (int k = 0; k < 256; k++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            waited = 0;
            while (!msb_ready && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (!msb_ready) begin
                check_output("wrap_ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            if ($urandom_range(1, 0) == 1) begin
                load_valid = 1'b0;
                repeat ($urandom_range(10, 0)) @(negedge clk);
            end
        end
        load_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_output("wrap_model_frames", ref_frames, 32'd256);
        check_output("wrap_frame", {24'd0, msb_frame}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
